// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Purpose  : Bit-parallel half adder. Each of WIDTH independent lanes
//            computes sum = a ^ b and carry = a & b. Combinational results
//            are offered directly. Registered copies with a valid strobe
//            serve pipelined datapaths. A saturating counter accumulates
//            the number of lane carries seen on qualified cycles.
// Ports    : clk        in   1      system clock, rising edge
//            rst_n      in   1      asynchronous active-low reset
//            a          in   WIDTH  operand A, one bit per lane
//            b          in   WIDTH  operand B, one bit per lane
//            in_valid   in   1      qualifies a/b for registers and counter
//            clr_cnt    in   1      synchronous clear of carry_cnt
//            sum        out  WIDTH  combinational a ^ b
//            carry      out  WIDTH  combinational a & b
//            sum_q      out  WIDTH  registered sum
//            carry_q    out  WIDTH  registered carry
//            out_valid  out  1      sum_q/carry_q updated on the last edge
//            carry_cnt  out  CNT_W  saturating count of lane carries
// Revision : 1.0 - initial release
// ============================================================================
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    // Popcount of WIDTH bits needs enough bits to represent WIDTH itself.
    localparam int POP_W = $clog2(WIDTH + 1);
    // Counter plus popcount is evaluated at this wider size so the
    // saturation compare cannot be fooled by a wrapped sum.
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] C_CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [POP_W-1:0] w_pop;
    logic [SUM_W-1:0] w_cnt_ext;
    logic [CNT_W-1:0] w_cnt_next;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    // Lanes are fully independent: no carry ripples between them.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            assign w_sum[i]   = a[i] ^ b[i];
            assign w_carry[i] = a[i] & b[i];
        end
    endgenerate

    assign sum   = w_sum;
    assign carry = w_carry;

    // Number of lanes producing a carry this cycle.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_carry[i]);
        end
    end

    always_comb begin
        w_cnt_ext  = {{POP_W{1'b0}}, r_cnt} + {{CNT_W{1'b0}}, w_pop};
        w_cnt_next = w_cnt_ext[CNT_W-1:0];
        if (w_cnt_ext > C_CNT_MAX) begin
            w_cnt_next = {CNT_W{1'b1}};
        end
    end

    // Data/valid pipeline stage. Data holds when not qualified, while the
    // strobe always reflects whether this edge performed a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
            r_valid <= in_valid;
        end
    end

    // Carry-event counter; clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign sum_q     = r_sum;
    assign carry_q   = r_carry;
    assign out_valid = r_valid;
    assign carry_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_adder
// Purpose  : Directed self-checking bench for half_adder. A 4-lane instance
//            with a 16-bit counter exercises the datapath and reset; a
//            1-lane instance with a 2-bit counter covers the truth table
//            and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_half_adder;

    logic       clk;
    logic       rst_n;

    // 4-lane instance
    logic [3:0]  a4, b4;
    logic        v4, clr4;
    logic [3:0]  sum4, carry4, sum_q4, carry_q4;
    logic        ov4;
    logic [15:0] cnt4;

    // 1-lane instance, narrow counter
    logic        a1, b1;
    logic        v1, clr1;
    logic        sum1, carry1, sum_q1, carry_q1;
    logic        ov1;
    logic [1:0]  cnt1;

    int n_checks;
    int n_fail;

    half_adder #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .in_valid  (v4),
        .clr_cnt   (clr4),
        .sum       (sum4),
        .carry     (carry4),
        .sum_q     (sum_q4),
        .carry_q   (carry_q4),
        .out_valid (ov4),
        .carry_cnt (cnt4)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (v1),
        .clr_cnt   (clr1),
        .sum       (sum1),
        .carry     (carry1),
        .sum_q     (sum_q1),
        .carry_q   (carry_q1),
        .out_valid (ov1),
        .carry_cnt (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Truth-table vectors for the single-lane instance: {a,b} -> {sum,carry}
    logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] tt_out [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        a4 = '0; b4 = '0; v4 = 1'b0; clr4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;

        #1;
        check("rst_sum_q",   32'(sum_q4),   32'h0);
        check("rst_carry_q", 32'(carry_q4), 32'h0);
        check("rst_valid",   32'(ov4),      32'h0);
        check("rst_cnt",     32'(cnt4),     32'h0);
        check("rst_cnt_w1",  32'(cnt1),     32'h0);

        // Combinational truth table; registers held in reset throughout.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_in[i][1];
            b1 = tt_in[i][0];
            #10;
            check("tt_sum",   32'(sum1),   32'(tt_out[i][1]));
            check("tt_carry", 32'(carry1), 32'(tt_out[i][0]));
        end

        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Basic capture
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        #1;
        check("comb_sum",  32'(sum4),   32'h6);
        check("comb_carry",32'(carry4), 32'h8);
        tick;
        check("cap_sum_q",   32'(sum_q4),   32'h6);
        check("cap_carry_q", 32'(carry_q4), 32'h8);
        check("cap_valid",   32'(ov4),      32'h1);
        check("cap_cnt",     32'(cnt4),     32'h1);

        // Unqualified inputs: comb follows, registers hold
        a4 = 4'b1111; b4 = 4'b0101; v4 = 1'b0;
        #1;
        check("nv_comb_sum",   32'(sum4),   32'hA);
        check("nv_comb_carry", 32'(carry4), 32'h5);
        tick;
        check("nv_sum_q",   32'(sum_q4),   32'h6);
        check("nv_carry_q", 32'(carry_q4), 32'h8);
        check("nv_valid",   32'(ov4),      32'h0);
        check("nv_cnt",     32'(cnt4),     32'h1);

        // All four lanes carry
        a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
        tick;
        check("all_sum_q",   32'(sum_q4),   32'h0);
        check("all_carry_q", 32'(carry_q4), 32'hF);
        check("all_cnt",     32'(cnt4),     32'h5);

        // Clear beats increment; data path still captures
        a4 = 4'b0011; b4 = 4'b0110; clr4 = 1'b1;
        tick;
        check("clr_cnt4",    32'(cnt4),     32'h0);
        check("clr_sum_q",   32'(sum_q4),   32'h5);
        check("clr_carry_q", 32'(carry_q4), 32'h2);
        check("clr_valid",   32'(ov4),      32'h1);
        clr4 = 1'b0;
        a4 = 4'b1111; b4 = 4'b1111;
        tick;
        check("post_clr_cnt", 32'(cnt4), 32'h4);

        // Saturation on the 2-bit counter
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("sat_cnt", 32'(cnt1), 32'(sat_exp[i]));
        end
        clr1 = 1'b1;
        tick;
        check("sat_clr", 32'(cnt1), 32'h0);
        clr1 = 1'b0;
        tick;
        check("sat_after_clr", 32'(cnt1), 32'h1);
        check("w1_valid",      32'(ov1),  32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sum_q",   32'(sum_q4),   32'h0);
        check("ar_carry_q", 32'(carry_q4), 32'h0);
        check("ar_valid",   32'(ov4),      32'h0);
        check("ar_cnt",     32'(cnt4),     32'h0);
        check("ar_cnt_w1",  32'(cnt1),     32'h0);
        check("ar_comb_carry", 32'(carry4), 32'hF);
        a4 = 4'b0011; b4 = 4'b0101;
        #1;
        check("ar_comb_sum2",   32'(sum4),   32'h6);
        check("ar_comb_carry2", 32'(carry4), 32'h1);

        // Release with in_valid low: nothing captured
        @(negedge clk);
        rst_n = 1'b1;
        v4 = 1'b0; v1 = 1'b0;
        tick;
        check("rel_valid",   32'(ov4),      32'h0);
        check("rel_carry_q", 32'(carry_q4), 32'h0);
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        tick;
        check("rel_sum_q", 32'(sum_q4), 32'h6);
        check("rel_valid2",32'(ov4),    32'h1);
        check("rel_cnt",   32'(cnt4),   32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
